// File: rtl/adt7420_i2c_responder.sv
// I2C read-only responder presenting a two-byte temperature register (ADT7420 style).
// Define ADT7420_RESP_GLITCH_FILTER_EN to add a 3-sample majority filter on scl/sda.
module adt7420_i2c_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h4B
) (
    input  logic       clk_200kHz,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] temp_msb,
    input  logic [7:0] temp_lsb,
    output logic       busy,
    output logic       read_done
);

    typedef enum logic [2:0] {IDLE, ADDR, ACK_ADDR, TX_BYTE, WAIT_MACK, IGNORE} state_t;

    state_t      state, state_n;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_c, sda_c, scl_p, sda_p;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [6:0]  shift, shift_n;
    logic [15:0] hold, hold_n;
    logic        sel, sel_n;
    logic        phase, phase_n;
    logic        sda_low, sda_low_n;
    logic        done_n;

    always_ff @(posedge clk_200kHz or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

`ifdef ADT7420_RESP_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    always_ff @(posedge clk_200kHz or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
        end
    end

    assign scl_c = (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
    assign sda_c = (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
`else
    assign scl_c = scl_sync[1];
    assign sda_c = sda_sync[1];
`endif

    always_ff @(posedge clk_200kHz or negedge rst_n) begin
        if (!rst_n) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_c;
            sda_p <= sda_c;
        end
    end

    logic       scl_rise, scl_fall, start_c, stop_c;
    logic [7:0] addr_byte, cur_byte, nxt_byte;

    assign scl_rise  = scl_c & ~scl_p;
    assign scl_fall  = ~scl_c & scl_p;
    assign start_c   = scl_c & scl_p & sda_p & ~sda_c;
    assign stop_c    = scl_c & scl_p & ~sda_p & sda_c;
    assign addr_byte = {shift, sda_c};
    assign cur_byte  = sel ? hold[7:0]  : hold[15:8];
    assign nxt_byte  = sel ? hold[15:8] : hold[7:0];

    always_ff @(posedge clk_200kHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 7'd0;
            hold      <= 16'd0;
            sel       <= 1'b0;
            phase     <= 1'b0;
            sda_low   <= 1'b0;
            read_done <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            hold      <= hold_n;
            sel       <= sel_n;
            phase     <= phase_n;
            sda_low   <= sda_low_n;
            read_done <= done_n;
        end
    end

    // phase: in ACK_ADDR marks the ACK pull-down as active; in TX_BYTE marks
    // that the next scl fall only ends the master's ACK clock and keeps bit 7.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        hold_n    = hold;
        sel_n     = sel;
        phase_n   = phase;
        sda_low_n = sda_low;
        done_n    = 1'b0;
        if (start_c) begin
            state_n   = ADDR;
            bit_cnt_n = 3'd0;
            phase_n   = 1'b0;
            sda_low_n = 1'b0;
        end else if (stop_c) begin
            state_n   = IDLE;
            phase_n   = 1'b0;
            sda_low_n = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_n   = addr_byte[6:0];
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (addr_byte[7:1] == DEV_ADDR && addr_byte[0]) begin
                            state_n = ACK_ADDR;
                            hold_n  = {temp_msb, temp_lsb};
                            sel_n   = 1'b0;
                            phase_n = 1'b0;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                ACK_ADDR: if (scl_fall) begin
                    if (!phase) begin
                        phase_n   = 1'b1;
                        sda_low_n = 1'b1;
                    end else begin
                        state_n   = TX_BYTE;
                        phase_n   = 1'b0;
                        bit_cnt_n = 3'd0;
                        sda_low_n = ~hold[15];
                    end
                end
                TX_BYTE: if (scl_fall) begin
                    if (phase) begin
                        phase_n = 1'b0;
                    end else if (bit_cnt == 3'd7) begin
                        sda_low_n = 1'b0;
                        state_n   = WAIT_MACK;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        sda_low_n = ~cur_byte[3'd6 - bit_cnt];
                    end
                end
                WAIT_MACK: if (scl_rise) begin
                    if (!sda_c) begin
                        state_n   = TX_BYTE;
                        sel_n     = ~sel;
                        bit_cnt_n = 3'd0;
                        phase_n   = 1'b1;
                        sda_low_n = ~nxt_byte[7];
                    end else begin
                        state_n = IGNORE;
                        done_n  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ACK_ADDR) || (state == TX_BYTE) || (state == WAIT_MACK);
    // Gated by rst_n so reset releases the line with no clock edge.
    assign sda  = (sda_low && rst_n) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_adt7420_i2c_responder.sv
// Bench for adt7420_i2c_responder: a timed I2C master drives reads; received bytes
// are checked by a monitor against expected bytes queued from a transfer-level model.
module tb_adt7420_i2c_responder;

    localparam int Q = 60;  // quarter scl period in time units (clk period is 10)

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       m_low;
    tri1        sda_w;
    logic [7:0] temp_msb, temp_lsb;
    logic       busy, read_done;

    assign sda_w = m_low ? 1'b0 : 1'bz;

    adt7420_i2c_responder #(.DEV_ADDR(7'h4B)) dut (
        .clk_200kHz(clk),
        .rst_n(rst_n),
        .scl(scl),
        .sda(sda_w),
        .temp_msb(temp_msb),
        .temp_lsb(temp_lsb),
        .busy(busy),
        .read_done(read_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int dut_low_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always @(posedge clk) begin
        if (read_done) done_cnt <= done_cnt + 1;
        if (!m_low && sda_w === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    // Scoreboard monitor: every byte the master receives is compared with the model.
    initial begin
        logic [7:0] g;
        forever begin
            wait (got_q.size() != 0);
            g = got_q.pop_front();
            if (exp_q.size() == 0) chk("sb_unexpected_byte", int'(g), -1);
            else chk("sb_byte", int'(g), int'(exp_q.pop_front()));
        end
    end

    task automatic bit_slot(input logic drv, output logic r);
        m_low = ~drv; #Q;
        scl = 1'b1;   #Q;
        r = sda_w;    #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_start();
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b1; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_slot(b[i], r);
        bit_slot(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] v);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_slot(1'b1, r);
            v[i] = r;
        end
        got_q.push_back(v);
        bit_slot(~mack, r);
    endtask

    // Full read transfer: n bytes, all ACKed except the last. The model answers only
    // for address byte 0x97 and returns MSB, LSB, MSB... from the values at address time.
    task automatic read_txn(input logic [7:0] a, input int n, input logic chg, input logic [7:0] new_msb);
        logic ack, exp_ack, r;
        logic [7:0] v;
        int d0, dl0, b0;
        d0 = done_cnt;
        exp_ack = (a == 8'h97);
        if (exp_ack)
            for (int i = 0; i < n; i++) exp_q.push_back((i % 2 == 0) ? temp_msb : temp_lsb);
        i2c_start();
        send_byte(a, ack);
        chk("addr_ack", int'(ack), int'(exp_ack));
        if (ack) begin
            chk("busy_in_xfer", int'(busy), 1);
            if (chg) begin
                temp_msb = new_msb;
                temp_lsb = ~temp_lsb;
            end
            for (int i = 0; i < n; i++) recv_byte(i != n - 1, v);
        end else begin
            dl0 = dut_low_cnt;
            b0  = busy_cnt;
            for (int i = 0; i < 9; i++) bit_slot(1'b1, r);
            chk("ignored_sda_released", dut_low_cnt - dl0, 0);
            chk("ignored_busy_low", busy_cnt - b0, 0);
        end
        i2c_stop();
        #Q;
        chk("read_done_pulses", done_cnt - d0, exp_ack ? 1 : 0);
        chk("busy_after_stop", int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        logic ack, r;
        logic [3:0] part;
        int d0, dl0;
        rst_n = 1'b0;
        scl = 1'b1;
        m_low = 1'b0;
        temp_msb = 8'h00;
        temp_lsb = 8'h00;
        #50;
        chk("rst_sda_released", int'(sda_w), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_read_done", int'(read_done), 0);
        #50 rst_n = 1'b1;
        #100;
        chk("post_rst_busy", int'(busy), 0);

        // Basic two-byte read
        temp_msb = 8'h0C; temp_lsb = 8'h80;
        read_txn(8'h97, 2, 1'b0, 8'h00);

        // Other address, then a write request: both ignored
        read_txn(8'h91, 1, 1'b0, 8'h00);
        read_txn(8'h96, 1, 1'b0, 8'h00);
        read_txn(8'h97, 2, 1'b0, 8'h00);

        // Third byte wraps to MSB; input change after address ACK is invisible
        temp_msb = 8'h0C; temp_lsb = 8'h80;
        read_txn(8'h97, 3, 1'b1, 8'h19);

        // Repeated START in the middle of byte 1 (bit 3 is 1 so the line is free)
        temp_msb = 8'($urandom) | 8'h08;
        temp_lsb = 8'($urandom);
        i2c_start();
        send_byte(8'h97, ack);
        chk("rs_addr_ack", int'(ack), 1);
        for (int i = 3; i >= 0; i--) begin
            bit_slot(1'b1, r);
            part[i] = r;
        end
        chk("rs_partial_bits", int'(part), int'(temp_msb[7:4]));
        temp_msb = 8'($urandom);
        temp_lsb = 8'($urandom);
        read_txn(8'h97, 2, 1'b0, 8'h00);

        // Reset while the responder drives a 0 data bit
        temp_msb = 8'($urandom) & 8'h7F;
        d0 = done_cnt;
        i2c_start();
        send_byte(8'h97, ack);
        chk("rst_mid_addr_ack", int'(ack), 1);
        m_low = 1'b0;
        chk("rst_mid_driving0", int'(sda_w), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sda_released", int'(sda_w), 1);
        chk("rst_mid_busy", int'(busy), 0);
        #19 rst_n = 1'b1;
        #10;
        dl0 = dut_low_cnt;
        for (int i = 0; i < 9; i++) bit_slot(1'b1, r);
        chk("rst_mid_no_start_quiet", dut_low_cnt - dl0, 0);
        chk("rst_mid_busy_idle", int'(busy), 0);
        i2c_stop();
        #Q;
        chk("rst_mid_no_read_done", done_cnt - d0, 0);
        temp_msb = 8'h0C; temp_lsb = 8'h80;
        read_txn(8'h97, 2, 1'b0, 8'h00);

        // Randomized transfers
        for (int k = 0; k < 8; k++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 2) != 0) ? 8'h97 : 8'($urandom);
            temp_msb = 8'($urandom);
            temp_lsb = 8'($urandom);
            read_txn(a, $urandom_range(1, 4), 1'($urandom), 8'($urandom));
        end

        #(10 * Q);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adt7420_i2c_responder.md
ADT7420_I2C_RESPONDER -- requirements
Module: adt7420_i2c_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h4B, the 7-bit target address the block answers to.
REQ-002 SHALL have port clk_200kHz  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port scl  input  1  I2C clock from the master; never driven.
REQ-005 SHALL have port sda  inout  1  open-drain I2C data line; driven 0 or high-Z only, never driven 1.
REQ-006 SHALL have port temp_msb  input  8  temperature MSB byte to return.
REQ-007 SHALL have port temp_lsb  input  8  temperature LSB byte to return.
REQ-008 SHALL have port busy  output  1  high while addressed and in a read transfer.
REQ-009 SHALL have port read_done  output  1  one-cycle pulse when the master NACKs a returned byte.

Function
REQ-010 SHALL pass scl and sda through 2-flop synchronizers; all edge/condition detection uses the synchronized values.
REQ-011 SHALL detect START as synced sda 1->0 while synced scl high, and STOP as synced sda 1->0 reversed (0->1) while scl high.
REQ-012 SHALL implement states IDLE, ADDR, ACK_ADDR, TX_BYTE, WAIT_MACK, IGNORE.
REQ-013 IDLE: sda released; START -> ADDR with bit counter cleared.
REQ-014 ADDR: shift one bit per scl rising edge, MSB first; after 8th bit compare [7:1] to DEV_ADDR and [0] to 1.
REQ-015 Match with RW=1 -> ACK_ADDR; snapshot {temp_msb, temp_lsb} into a 16-bit hold register in that same cycle; byte select = MSB.
REQ-016 Address mismatch or RW=0 -> IGNORE (no ACK; sda stays released).
REQ-017 ACK_ADDR: drive sda low from the first scl falling edge after bit 8 until the next scl falling edge, then -> TX_BYTE.
REQ-018 TX_BYTE: place bit 7 of the selected byte on sda immediately on entry; change bits only on scl falling edges; 8 bits, 0 drives low, 1 releases.
REQ-019 After the 8th bit's scl falling edge, release sda and -> WAIT_MACK.
REQ-020 WAIT_MACK: sample sda on scl rising; 0 (ACK) -> TX_BYTE with byte select toggled (MSB->LSB->MSB wrap, same snapshot); 1 (NACK) -> IGNORE and pulse read_done.
REQ-021 START in any state -> ADDR (repeated start); STOP in any state -> IDLE; both release sda in the next cycle.
REQ-022 IGNORE: sda released; leaves only on START or STOP.
REQ-023 busy SHALL be high in ACK_ADDR, TX_BYTE, WAIT_MACK; low otherwise.
REQ-024 sda drive changes SHALL occur no later than 3 clk_200kHz cycles after the scl edge that causes them (4 with filter, see REQ-028).
REQ-025 temp_msb/temp_lsb changes after the snapshot SHALL NOT affect bytes of the current transfer.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, sda high-Z, busy 0, read_done 0, shift/hold registers 0, synchronizers 1.
REQ-027 Reset asserted mid-transfer SHALL release sda without waiting for any clock edge; after release the block waits for a fresh START.

Configuration
REQ-028 With ADT7420_RESP_GLITCH_FILTER_EN defined, synced scl and sda SHALL each pass a 3-sample majority filter (one extra cycle latency); single-cycle pulses are rejected.
REQ-029 Without ADT7420_RESP_GLITCH_FILTER_EN, no filter is built and single-cycle pulses are treated as real edges.

Verification
REQ-030 temp_msb=0x0C, temp_lsb=0x80, master reads 0x97, ACKs byte 1, NACKs byte 2 -> address ACK, bytes 0x0C then 0x80, read_done one pulse, busy low after.
REQ-031 Master sends 0x91 (addr 0x48 read) -> sda never driven low; state IGNORE until STOP; busy stays 0.
REQ-032 Master sends 0x96 (write) -> no ACK; next START with 0x97 served normally.
REQ-033 Master ACKs byte 2 (0x80) -> third byte returned is 0x0C; temp_msb changed to 0x19 after address ACK still yields 0x0C.
REQ-034 Repeated START after 4 bits of byte 1, then 0x97 -> sda released next cycle, fresh snapshot, byte 1 restarts at bit 7.
REQ-035 rst_n pulled low while driving a 0 data bit -> sda high-Z in the same cycle; read_done not pulsed.
